// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//   Shares a single UART transmitter between NUM_REQ byte sources. A
//   round-robin arbiter picks one requester per byte, drives the trmt/tx_data
//   strobe into the UART, then waits for tx_done. A timeout guard releases
//   the transmitter if tx_done never arrives.
//
// Ports
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   req          per-requester level request, held until its own gnt
//   req_data     byte i at [8i+7:8i], stable while req[i] is high
//   gnt          one-cycle pulse, byte captured
//   done         one-cycle pulse, owner's byte finished transmitting
//   err/err_id   one-cycle timeout pulse; err_id holds the last timed-out owner
//   busy         arbiter is not idle
//   trmt         one-cycle start strobe to the UART
//   tx_data      byte to the UART, held until the next load
//   tx_done      UART completion level, cleared by the UART on trmt
// -----------------------------------------------------------------------------
module uart_tx_arb #(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 8192,
   parameter int GAP_CYC = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REQ-1:0]         done,
   output logic                       err,
   output logic [$clog2(NUM_REQ)-1:0] err_id,
   output logic                       busy,
   output logic                       trmt,
   output logic [7:0]                 tx_data,
   input  logic                       tx_done
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYC);
   localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, XMIT, GAP} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 err_q, err_d;
   logic [IW-1:0]        err_id_q, err_id_d;
   logic                 trmt_q, trmt_d;
   logic [7:0]           tx_data_q, tx_data_d;

   // Round-robin pick: first set req bit scanning upward from rr_ptr, wrapping.
   logic                 found;
   logic [IW-1:0]        sel;

   always_comb begin
      int idx;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
   end

   always_comb begin
      logic fin;
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      tmo_cnt_d = tmo_cnt_q;
      gap_cnt_d = gap_cnt_q;
      gnt_d     = '0;
      done_d    = '0;
      err_d     = 1'b0;
      err_id_d  = err_id_q;
      trmt_d    = 1'b0;
      tx_data_d = tx_data_q;
      fin       = 1'b0;

      case (state_q)
         IDLE: begin
            if (found) begin
               tx_data_d  = req_data[8*int'(sel) +: 8];
               owner_d    = sel;
               trmt_d     = 1'b1;
               gnt_d[sel] = 1'b1;
               tmo_cnt_d  = TMO_ONE;
               state_d    = XMIT;
            end
         end
         XMIT: begin
            // tx_done in the trmt cycle may be left over from the previous
            // byte, so it only qualifies from the second XMIT cycle onward.
            // A qualified tx_done beats a simultaneous timeout.
            if (tmo_cnt_q != TMO_ONE && tx_done) begin
               done_d[owner_q] = 1'b1;
               fin             = 1'b1;
            end else if (tmo_cnt_q >= TMO_MAX) begin
               err_d    = 1'b1;
               err_id_d = owner_q;
               fin      = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;   // never passes TIMEOUT
            end
            if (fin) begin
               rr_ptr_d  = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
               tmo_cnt_d = '0;
               if (GAP_CYC > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = GW'(1);
               end else begin
                  state_d   = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q >= GAP_MAX) begin
               state_d   = IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         tmo_cnt_q <= '0;
         gap_cnt_q <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         err_id_q  <= '0;
         trmt_q    <= 1'b0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         tmo_cnt_q <= tmo_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_id_q  <= err_id_d;
         trmt_q    <= trmt_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign err     = err_q;
   assign err_id  = err_id_q;
   assign busy    = (state_q != IDLE);
   assign trmt    = trmt_q;
   assign tx_data = tx_data_q;

endmodule
